// File: rtl/dmem_pkg.sv
// Shared types, defaults and helpers for the parametrised data memory controller.
package dmem_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } dmem_state_t;

   localparam int unsigned DMEM_DATA_W_DEF = 8;
   localparam int unsigned DMEM_LANE_W_DEF = 8;
   localparam int unsigned DMEM_ADDR_W_DEF = 8;

   // Widest lane the parity helper accepts; narrower lanes are zero-extended.
   localparam int unsigned DMEM_MAX_LANE_W = 64;

   function automatic int unsigned dmem_nlane(input int unsigned data_w,
                                              input int unsigned lane_w);
      return data_w / lane_w;
   endfunction

   // Even parity: the stored bit makes the lane plus parity have an even count of ones.
   function automatic logic dmem_lane_parity(input logic [DMEM_MAX_LANE_W-1:0] lane);
      return ^lane;
   endfunction

endpackage

// File: rtl/dmem_clear_seq.sv
// Clear sequencer: owns the CLEAR/IDLE state, the zeroing pointer and the busy/ready flags.
module dmem_clear_seq
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W = DMEM_ADDR_W_DEF,
   parameter int unsigned DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clr_req,
   output logic              busy,
   output logic              req_ready,
   output logic              clr_we_c,
   output logic [ADDR_W-1:0] clr_addr_c
);

   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   dmem_state_t       state;
   logic [ADDR_W-1:0] ptr;

   // State, pointer and flags all move together so busy/req_ready stay registered.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= CLEAR;
         ptr       <= '0;
         busy      <= 1'b1;
         req_ready <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               if (ptr == LAST_PTR) begin
                  state     <= IDLE;
                  ptr       <= '0;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
               end else begin
                  ptr <= ptr + ADDR_W'(1);
               end
            end
            IDLE: begin
               if (clr_req) begin
                  state     <= CLEAR;
                  ptr       <= '0;
                  busy      <= 1'b1;
                  req_ready <= 1'b0;
               end
            end
            default: begin
               state     <= CLEAR;
               ptr       <= '0;
               busy      <= 1'b1;
               req_ready <= 1'b0;
            end
         endcase
      end
   end

   // No array write on a reset edge: the pass restarts cleanly from address 0.
   assign clr_we_c   = (state == CLEAR) && reset_n;
   assign clr_addr_c = ptr;

endmodule

// File: rtl/dmem_ctrl.sv
// Single-port data memory with lane write mask, registered read and hardware clear pass.
// Optional per-lane even parity storage and checking when DMEM_PARITY_EN is defined.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter  int unsigned DATA_W = DMEM_DATA_W_DEF,
   parameter  int unsigned LANE_W = DMEM_LANE_W_DEF,
   parameter  int unsigned ADDR_W = DMEM_ADDR_W_DEF,
   parameter  int unsigned DEPTH  = 2**ADDR_W,
   localparam int unsigned NLANE  = dmem_nlane(DATA_W, LANE_W)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clr_req,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [NLANE-1:0]  req_wmask,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output logic              perr
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              clr_we_c;
   logic [ADDR_W-1:0] clr_addr_c;
   logic              accept_c;
   logic              in_range_c;
   logic              wr_en_c;
   logic              rd_en_c;
   logic [IDX_W-1:0]  idx_c;
   logic [IDX_W-1:0]  clr_idx_c;

   dmem_clear_seq #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_clear_seq (
      .clk        (clk),
      .reset_n    (reset_n),
      .clr_req    (clr_req),
      .busy       (busy),
      .req_ready  (req_ready),
      .clr_we_c   (clr_we_c),
      .clr_addr_c (clr_addr_c)
   );

   // A request in flight at a reset edge is dropped along with everything else.
   assign accept_c   = req_valid && req_ready && reset_n;
   assign in_range_c = (32'(req_addr) < DEPTH);
   assign wr_en_c    = accept_c && req_we && in_range_c;
   assign rd_en_c    = accept_c && !req_we;
   assign idx_c      = IDX_W'(req_addr);
   assign clr_idx_c  = IDX_W'(clr_addr_c);

   // Array write port: the clear pass has priority, though ready is low then anyway.
   always_ff @(posedge clk) begin
      if (clr_we_c) begin
         mem[clr_idx_c] <= '0;
      end else if (wr_en_c) begin
         for (int i = 0; i < NLANE; i++) begin
            if (req_wmask[i]) begin
               mem[idx_c][i*LANE_W +: LANE_W] <= req_wdata[i*LANE_W +: LANE_W];
            end
         end
      end
   end

   // Response registers; rsp_rdata holds until the next read response.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= rd_en_c;
         rsp_err   <= accept_c && !in_range_c;
         if (rd_en_c) begin
            rsp_rdata <= in_range_c ? mem[idx_c] : '0;
         end
      end
   end

`ifdef DMEM_PARITY_EN
   logic [NLANE-1:0] par [DEPTH];
   logic             rd_perr_c;

   always_ff @(posedge clk) begin
      if (clr_we_c) begin
         par[clr_idx_c] <= '0;
      end else if (wr_en_c) begin
         for (int i = 0; i < NLANE; i++) begin
            if (req_wmask[i]) begin
               par[idx_c][i] <= dmem_lane_parity(DMEM_MAX_LANE_W'(req_wdata[i*LANE_W +: LANE_W]));
            end
         end
      end
   end

   // Any lane whose recomputed parity disagrees with its stored bit flags the read.
   always_comb begin
      rd_perr_c = 1'b0;
      for (int i = 0; i < NLANE; i++) begin
         if (dmem_lane_parity(DMEM_MAX_LANE_W'(mem[idx_c][i*LANE_W +: LANE_W])) != par[idx_c][i]) begin
            rd_perr_c = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         perr <= 1'b0;
      end else begin
         perr <= rd_en_c && in_range_c && rd_perr_c;
      end
   end
`else
   assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl (32-bit word, 8-bit lanes, 200 words, 8-bit address).
module tb_dmem_ctrl;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned LANE_W = 8;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DEPTH  = 200;
   localparam int unsigned NLANE  = 4;
   localparam int          LIMIT  = 4 * DEPTH;

   logic              clk;
   logic              reset_n;
   logic              clr_req;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [NLANE-1:0]  req_wmask;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              busy;
   logic              perr;

   int n_vec = 0;
   int n_err = 0;

   dmem_ctrl #(
      .DATA_W (DATA_W),
      .LANE_W (LANE_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .clr_req   (clr_req),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wmask (req_wmask),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .perr      (perr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [NLANE-1:0] m);
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
      tick();
      req_valid = 1'b0; req_we = 1'b0;
   endtask

   task automatic do_read(input logic [ADDR_W-1:0] a);
      req_valid = 1'b1; req_we = 1'b0; req_addr = a;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      logic bad;
      reset_n = 1'b0;
      tick();
      tick();
      n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", req_ready); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", busy); end
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
      n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
      n_vec++; if (perr !== 1'b0) begin n_err++; $display("FAIL reset_perr: got %b want 0", perr); end
      reset_n = 1'b1;
      n = 0;
      bad = 1'b0;
      while (req_ready !== 1'b1 && n < LIMIT) begin
         tick();
         n++;
         if (req_ready !== 1'b1 && busy !== 1'b1) bad = 1'b1;
      end
      n_vec++; if (n != DEPTH) begin n_err++; $display("FAIL reset_clear_len: got %0d edges want %0d", n, DEPTH); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_idle: got %b want 0", busy); end
      n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL reset_busy_during_clear: got %b want 0", bad); end
   endtask

   // Every word zero after the clear, streamed one read per cycle.
   task automatic test_back_to_back();
      req_valid = 1'b1; req_we = 1'b0;
      for (int a = 0; a < int'(DEPTH); a++) begin
         req_addr = ADDR_W'(a);
         tick();
         n_vec++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_read[%0d]: got v=%b d=%h e=%b want v=1 d=0 e=0", a, rsp_valid, rsp_rdata, rsp_err);
         end
      end
      req_valid = 1'b0;
      tick();
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle_valid: got %b want 0", rsp_valid); end
   endtask

   task automatic test_lanes();
      do_write(8'd5, 32'hAABBCCDD, 4'b1111);
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL lane_write_no_rsp: got %b want 0", rsp_valid); end
      do_write(8'd5, 32'h11223344, 4'b0101);
      do_read(8'd5);
      n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL lane_rsp_valid: got %b want 1", rsp_valid); end
      n_vec++; if (rsp_rdata !== 32'hAA22CC44) begin n_err++; $display("FAIL lane_merge: got %h want aa22cc44", rsp_rdata); end
      tick();
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL lane_valid_pulse: got %b want 0", rsp_valid); end
      do_write(8'd5, 32'hFFFFFFFF, 4'b0000);
      n_vec++; if (rsp_rdata !== 32'hAA22CC44) begin n_err++; $display("FAIL lane_rdata_hold: got %h want aa22cc44", rsp_rdata); end
      do_read(8'd5);
      n_vec++; if (rsp_rdata !== 32'hAA22CC44) begin n_err++; $display("FAIL lane_mask_zero: got %h want aa22cc44", rsp_rdata); end
      do_write(8'd6, 32'h01020304, 4'b1010);
      do_read(8'd6);
      n_vec++; if (rsp_rdata !== 32'h01000300) begin n_err++; $display("FAIL lane_mask_1010: got %h want 01000300", rsp_rdata); end
   endtask

   task automatic test_range();
      do_write(8'd199, 32'h12345678, 4'b1111);
      n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL range_wr_199_err: got %b want 0", rsp_err); end
      do_write(8'd210, 32'h0000005A, 4'b1111);
      n_vec++; if (rsp_err !== 1'b1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL range_wr_210: got e=%b v=%b want e=1 v=0", rsp_err, rsp_valid); end
      tick();
      n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL range_err_pulse: got %b want 0", rsp_err); end
      do_read(8'd210);
      n_vec++; if (rsp_err !== 1'b1 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin n_err++; $display("FAIL range_rd_210: got e=%b v=%b d=%h want e=1 v=1 d=0", rsp_err, rsp_valid, rsp_rdata); end
      do_read(8'd199);
      n_vec++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h12345678) begin n_err++; $display("FAIL range_rd_199: got e=%b d=%h want e=0 d=12345678", rsp_err, rsp_rdata); end
      do_read(8'd200);
      n_vec++; if (rsp_err !== 1'b1 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin n_err++; $display("FAIL range_rd_200: got e=%b v=%b d=%h want e=1 v=1 d=0", rsp_err, rsp_valid, rsp_rdata); end
   endtask

   task automatic test_clear_req();
      int n;
      do_write(8'd3, 32'h00000077, 4'b1111);
      clr_req = 1'b1;
      do_read(8'd3);
      clr_req = 1'b0;
      n_vec++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h77) begin n_err++; $display("FAIL clr_same_edge_read: got v=%b d=%h want v=1 d=77", rsp_valid, rsp_rdata); end
      n_vec++; if (busy !== 1'b1 || req_ready !== 1'b0) begin n_err++; $display("FAIL clr_enter: got busy=%b ready=%b want 1 0", busy, req_ready); end
      n = 0;
      while (req_ready !== 1'b1 && n < LIMIT) begin
         clr_req = (n == 50);
         tick();
         n++;
      end
      clr_req = 1'b0;
      n_vec++; if (n != DEPTH) begin n_err++; $display("FAIL clr_len: got %0d edges want %0d", n, DEPTH); end
      do_read(8'd3);
      n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL clr_addr3: got %h want 0", rsp_rdata); end
      do_read(8'd199);
      n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL clr_addr199: got %h want 0", rsp_rdata); end
   endtask

   task automatic test_reset_mid();
      int n;
      do_write(8'd9, 32'hCAFEF00D, 4'b1111);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int i = 0; i < 100; i++) tick();
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b want 1", busy); end
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      n_vec++; if (busy !== 1'b1 || req_ready !== 1'b0) begin n_err++; $display("FAIL mid_reset_flags: got busy=%b ready=%b want 1 0", busy, req_ready); end
      n = 0;
      while (req_ready !== 1'b1 && n < LIMIT) begin
         tick();
         n++;
      end
      n_vec++; if (n != DEPTH) begin n_err++; $display("FAIL mid_restart_len: got %0d edges want %0d", n, DEPTH); end
      do_read(8'd9);
      n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL mid_addr9: got %h want 0", rsp_rdata); end
   endtask

`ifdef DMEM_PARITY_EN
   task automatic test_parity();
      do_write(8'd7, 32'h0000000F, 4'b1111);
      do_read(8'd7);
      n_vec++; if (rsp_valid !== 1'b1 || perr !== 1'b0) begin n_err++; $display("FAIL par_clean: got v=%b perr=%b want 1 0", rsp_valid, perr); end
      dut.mem[7] = dut.mem[7] ^ 32'h00000001;
      do_read(8'd7);
      n_vec++; if (rsp_valid !== 1'b1 || perr !== 1'b1) begin n_err++; $display("FAIL par_flip: got v=%b perr=%b want 1 1", rsp_valid, perr); end
      n_vec++; if (rsp_rdata !== 32'h0000000E) begin n_err++; $display("FAIL par_flip_data: got %h want 0000000e", rsp_rdata); end
      tick();
      n_vec++; if (perr !== 1'b0) begin n_err++; $display("FAIL par_pulse: got %b want 0", perr); end
   endtask
`endif

   initial begin
      reset_n   = 1'b0;
      clr_req   = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_wmask = '0;
      test_reset();
      test_back_to_back();
      test_lanes();
      test_range();
      test_clear_req();
      test_reset_mid();
`ifdef DMEM_PARITY_EN
      test_parity();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
